// File: rtl/pfpu_ctlif2.sv
// pfpu_ctlif2: CSR control interface for the PFPU core.
// Owns the run configuration, ISR/IER, busy-safe start and the CSR read mux.
// Define PFPU_CTLIF2_DIAG_EN to build the diagnostic counters, LASTDMA, PC and RUNCYC.
`timescale 1ns/1ps
module pfpu_ctlif2 #(
  parameter logic [4:0]  csr_addr  = 5'h0,
  parameter int unsigned mesh_bits = 7,
  parameter int unsigned page_bits = 2,
  parameter int unsigned cnt_bits  = 14
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [14:0]          csr_a,
  input  logic                 csr_we,
  input  logic [31:0]          csr_di,
  output logic [31:0]          csr_do,
  output logic                 irq,
  output logic                 start,
  input  logic                 busy,
  output logic [28:0]          dma_base,
  output logic [mesh_bits-1:0] hmesh_last,
  output logic [mesh_bits-1:0] vmesh_last,
  output logic [6:0]           cr_addr,
  input  logic [31:0]          cr_di,
  output logic [31:0]          cr_do,
  output logic                 cr_w_en,
  output logic [page_bits-1:0] cp_page,
  output logic [8:0]           cp_offset,
  input  logic [31:0]          cp_di,
  output logic [31:0]          cp_do,
  output logic                 cp_w_en,
  input  logic                 vnext,
  input  logic                 err_collision,
  input  logic                 err_stray,
  input  logic [10:0]          pc,
  input  logic [31:0]          wbm_adr_o,
  input  logic                 wbm_ack_i
);

  logic                 sel_c, ctl_acc_c, ctl_wr_c, start_req_c, start_d, done_c;
  logic [3:0]           idx_c;
  logic [1:0]           isr_q, isr_d, ier_q;
  logic                 old_busy_q, start_q, irq_q, cr_sel_q, cp_sel_q;
  logic [28:0]          dma_base_q;
  logic [mesh_bits-1:0] hmesh_q, vmesh_q;
  logic [page_bits-1:0] page_q;
  logic [31:0]          rd_d, rd_q;
  logic [31:0]          vertex_rd, coll_rd, stray_rd, lastdma_rd, pc_rd, runcyc_rd;

  // Address decode and memory passthrough
  assign sel_c       = (csr_a[14:10] == csr_addr);
  assign ctl_acc_c   = sel_c & ~csr_a[9] & ~csr_a[8];
  assign ctl_wr_c    = ctl_acc_c & csr_we;
  assign idx_c       = csr_a[3:0];
  assign start_req_c = ctl_wr_c & (idx_c == 4'h0) & csr_di[0];
  assign start_d     = start_req_c & ~busy;
  assign done_c      = old_busy_q & ~busy;

  assign cp_w_en   = sel_c & csr_a[9] & csr_we;
  assign cr_w_en   = sel_c & ~csr_a[9] & csr_a[8] & csr_we;
  assign cp_offset = csr_a[8:0];
  assign cr_addr   = csr_a[6:0];
  assign cp_do     = csr_di;
  assign cr_do     = csr_di;

`ifdef PFPU_CTLIF2_DIAG_EN
  logic [cnt_bits-1:0] vertex_q, coll_q, stray_q;
  logic [31:0]         runcyc_q, last_dma_q;

  // Saturating event counters and run-cycle counter; a start clear beats an increment
  always_ff @(posedge sys_clk) begin
    if (sys_rst || start_d) begin
      vertex_q <= '0;
      coll_q   <= '0;
      stray_q  <= '0;
      runcyc_q <= '0;
    end else begin
      if (vnext && (vertex_q != '1))       vertex_q <= vertex_q + cnt_bits'(1);
      if (err_collision && (coll_q != '1)) coll_q   <= coll_q + cnt_bits'(1);
      if (err_stray && (stray_q != '1))    stray_q  <= stray_q + cnt_bits'(1);
      if (busy && (runcyc_q != '1))        runcyc_q <= runcyc_q + 32'd1;
    end
  end

  // Last acknowledged DMA address, deliberately left out of reset
  always_ff @(posedge sys_clk) begin
    if (wbm_ack_i) last_dma_q <= wbm_adr_o;
  end

  assign vertex_rd  = 32'(vertex_q);
  assign coll_rd    = 32'(coll_q);
  assign stray_rd   = 32'(stray_q);
  assign lastdma_rd = last_dma_q;
  assign pc_rd      = 32'(pc);
  assign runcyc_rd  = runcyc_q;
`else
  logic unused_diag;
  assign unused_diag = ^{vnext, err_collision, err_stray, pc, wbm_adr_o, wbm_ack_i};
  assign vertex_rd   = '0;
  assign coll_rd     = '0;
  assign stray_rd    = '0;
  assign lastdma_rd  = '0;
  assign pc_rd       = '0;
  assign runcyc_rd   = '0;
`endif

  // Sticky interrupt status: W1C first, then new events so a set wins
  always_comb begin
    isr_d = isr_q;
    if (ctl_wr_c && (idx_c == 4'hA)) isr_d = isr_q & ~csr_di[1:0];
    isr_d = isr_d | {start_req_c & busy, done_c};
  end

  // Control register read mux, registered for one-cycle latency
  always_comb begin
    rd_d = '0;
    if (ctl_acc_c) begin
      case (idx_c)
        4'h0:    rd_d = {31'b0, busy};
        4'h1:    rd_d = {dma_base_q, 3'b000};
        4'h2:    rd_d = 32'(hmesh_q);
        4'h3:    rd_d = 32'(vmesh_q);
        4'h4:    rd_d = 32'(page_q);
        4'h5:    rd_d = vertex_rd;
        4'h6:    rd_d = coll_rd;
        4'h7:    rd_d = stray_rd;
        4'h8:    rd_d = lastdma_rd;
        4'h9:    rd_d = pc_rd;
        4'hA:    rd_d = {30'b0, isr_q};
        4'hB:    rd_d = {30'b0, ier_q};
        4'hC:    rd_d = runcyc_rd;
        default: rd_d = '0;
      endcase
    end
  end

  // Configuration registers, interrupt state, start pulse and read select flags
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      start_q    <= 1'b0;
      irq_q      <= 1'b0;
      old_busy_q <= 1'b0;
      dma_base_q <= '0;
      hmesh_q    <= '0;
      vmesh_q    <= '0;
      page_q     <= '0;
      isr_q      <= 2'b00;
      ier_q      <= 2'b01;
      rd_q       <= '0;
      cr_sel_q   <= 1'b0;
      cp_sel_q   <= 1'b0;
    end else begin
      start_q    <= start_d;
      irq_q      <= |(isr_q & ier_q);
      old_busy_q <= busy;
      isr_q      <= isr_d;
      rd_q       <= rd_d;
      cr_sel_q   <= sel_c & ~csr_a[9] & csr_a[8];
      cp_sel_q   <= sel_c & csr_a[9];
      if (ctl_wr_c) begin
        case (idx_c)
          4'h1:    dma_base_q <= csr_di[31:3];
          4'h2:    hmesh_q    <= csr_di[mesh_bits-1:0];
          4'h3:    vmesh_q    <= csr_di[mesh_bits-1:0];
          4'h4:    page_q     <= csr_di[page_bits-1:0];
          4'hB:    ier_q      <= csr_di[1:0];
          default: ;
        endcase
      end
    end
  end

  assign csr_do     = rd_q | ({32{cr_sel_q}} & cr_di) | ({32{cp_sel_q}} & cp_di);
  assign start      = start_q;
  assign irq        = irq_q;
  assign dma_base   = dma_base_q;
  assign hmesh_last = hmesh_q;
  assign vmesh_last = vmesh_q;
  assign cp_page    = page_q;

endmodule

// File: tb/tb_pfpu_ctlif2.sv
// Self-checking bench for pfpu_ctlif2: directed sequences, a decode table and
// randomized traffic against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pfpu_ctlif2;
  localparam int CNT_MAX = 15;
`ifdef PFPU_CTLIF2_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif
  localparam logic [14:0] IDLE_A = 15'h7C00;

  logic        sys_clk = 1'b0;
  logic        sys_rst, csr_we, irq, start, busy, cr_w_en, cp_w_en;
  logic        vnext, err_collision, err_stray, wbm_ack_i;
  logic [14:0] csr_a;
  logic [31:0] csr_di, csr_do, cr_di, cr_do, cp_di, cp_do, wbm_adr_o;
  logic [28:0] dma_base;
  logic [6:0]  hmesh_last, vmesh_last, cr_addr;
  logic [1:0]  cp_page;
  logic [8:0]  cp_offset;
  logic [10:0] pc;

  pfpu_ctlif2 #(.csr_addr(5'h0), .mesh_bits(7), .page_bits(2), .cnt_bits(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
    .csr_di(csr_di), .csr_do(csr_do), .irq(irq), .start(start), .busy(busy),
    .dma_base(dma_base), .hmesh_last(hmesh_last), .vmesh_last(vmesh_last),
    .cr_addr(cr_addr), .cr_di(cr_di), .cr_do(cr_do), .cr_w_en(cr_w_en),
    .cp_page(cp_page), .cp_offset(cp_offset), .cp_di(cp_di), .cp_do(cp_do),
    .cp_w_en(cp_w_en), .vnext(vnext), .err_collision(err_collision),
    .err_stray(err_stray), .pc(pc), .wbm_adr_o(wbm_adr_o), .wbm_ack_i(wbm_ack_i)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [28:0]     m_dma;
  logic [6:0]      m_h, m_v;
  logic [1:0]      m_page, m_ier, m_isr;
  int              m_vtx, m_col, m_str;
  longint unsigned m_run;
  logic [31:0]     m_lastdma, m_rdv;
  bit              m_oldbusy, m_start, m_irq;
  int              m_rdk;

  typedef struct {
    logic [14:0] a;
    logic        we;
    logic [31:0] di;
    logic        cr_w;
    logic        cp_w;
    logic [6:0]  cr_a;
    logic [8:0]  cp_off;
  } dec_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    case (idx)
      4'h0: return {31'b0, busy};
      4'h1: return {m_dma, 3'b000};
      4'h2: return 32'(m_h);
      4'h3: return 32'(m_v);
      4'h4: return 32'(m_page);
      4'h5: return DIAG ? 32'(m_vtx) : 32'h0;
      4'h6: return DIAG ? 32'(m_col) : 32'h0;
      4'h7: return DIAG ? 32'(m_str) : 32'h0;
      4'h8: return DIAG ? m_lastdma : 32'h0;
      4'h9: return DIAG ? 32'(pc) : 32'h0;
      4'hA: return 32'(m_isr);
      4'hB: return 32'(m_ier);
      4'hC: return DIAG ? 32'(m_run) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int sat(input int v, input logic ev);
    return (v + int'(ev) > CNT_MAX) ? CNT_MAX : v + int'(ev);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    int         kind;
    logic [3:0] idx;
    logic       ctlw, req, go;
    logic [1:0] isr_n;
    if (sys_rst) begin
      m_dma = '0; m_h = '0; m_v = '0; m_page = '0; m_ier = 2'b01; m_isr = '0;
      m_vtx = 0; m_col = 0; m_str = 0; m_run = 0;
      m_oldbusy = 0; m_start = 0; m_irq = 0; m_rdk = 0; m_rdv = '0;
    end else begin
      if (csr_a[14:10] != 5'h0) kind = 0;
      else if (csr_a[9])        kind = 3;
      else if (csr_a[8])        kind = 2;
      else                      kind = 1;
      idx  = csr_a[3:0];
      ctlw = (kind == 1) && csr_we;
      req  = ctlw && (idx == 4'h0) && csr_di[0];
      go   = req && !busy;
      m_rdv = (kind == 1) ? m_read(idx) : 32'h0;
      m_rdk = kind;
      isr_n = m_isr;
      if (ctlw && idx == 4'hA) isr_n = isr_n & ~csr_di[1:0];
      if (req && busy)         isr_n[1] = 1'b1;
      if (m_oldbusy && !busy)  isr_n[0] = 1'b1;
      m_irq = ((m_isr & m_ier) != 2'b00);
      m_isr = isr_n;
      if (ctlw) begin
        case (idx)
          4'h1: m_dma  = csr_di[31:3];
          4'h2: m_h    = csr_di[6:0];
          4'h3: m_v    = csr_di[6:0];
          4'h4: m_page = csr_di[1:0];
          4'hB: m_ier  = csr_di[1:0];
          default: ;
        endcase
      end
      if (go) begin
        m_vtx = 0; m_col = 0; m_str = 0; m_run = 0;
      end else begin
        m_vtx = sat(m_vtx, vnext);
        m_col = sat(m_col, err_collision);
        m_str = sat(m_str, err_stray);
        if (busy && m_run < 64'hFFFF_FFFF) m_run = m_run + 1;
      end
      m_oldbusy = busy;
      m_start   = go;
    end
    if (wbm_ack_i) m_lastdma = wbm_adr_o;
  endtask

  function automatic logic [31:0] exp_do();
    case (m_rdk)
      1:       return m_rdv;
      2:       return cr_di;
      3:       return cp_di;
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    model_step();
    @(posedge sys_clk);
    #1;
    chk("start", 32'(start), 32'(m_start));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("csr_do", csr_do, exp_do());
    chk("dma_base", 32'(dma_base), 32'(m_dma));
    chk("hmesh_last", 32'(hmesh_last), 32'(m_h));
    chk("vmesh_last", 32'(vmesh_last), 32'(m_v));
    chk("cp_page", 32'(cp_page), 32'(m_page));
  endtask

  task automatic csr_wr(input logic [14:0] a, input logic [31:0] d);
    csr_a = a; csr_we = 1'b1; csr_di = d;
    step();
    csr_we = 1'b0; csr_a = IDLE_A;
  endtask

  task automatic csr_rd(input logic [14:0] a, output logic [31:0] v);
    csr_a = a; csr_we = 1'b0;
    step();
    v = csr_do;
    csr_a = IDLE_A;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_vec_t    vecs[7];
    logic [31:0] v;
    int          r;

    vecs[0] = '{15'h0105, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 7'h05, 9'h105};
    vecs[1] = '{15'h0203, 1'b1, 32'h11223344, 1'b0, 1'b1, 7'h03, 9'h003};
    vecs[2] = '{15'h0105, 1'b0, 32'h55AA55AA, 1'b0, 1'b0, 7'h05, 9'h105};
    vecs[3] = '{15'h03FF, 1'b1, 32'h0000FFFF, 1'b0, 1'b1, 7'h7F, 9'h1FF};
    vecs[4] = '{15'h0505, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 7'h05, 9'h105};
    vecs[5] = '{15'h000D, 1'b1, 32'h00000000, 1'b0, 1'b0, 7'h0D, 9'h00D};
    vecs[6] = '{15'h0183, 1'b1, 32'h87654321, 1'b1, 1'b0, 7'h03, 9'h183};

    sys_rst = 1'b1; csr_a = IDLE_A; csr_we = 1'b0; csr_di = '0; busy = 1'b0;
    vnext = 1'b0; err_collision = 1'b0; err_stray = 1'b0; pc = 11'h123;
    wbm_adr_o = 32'h0; wbm_ack_i = 1'b0; cr_di = 32'h13579BDF; cp_di = 32'h2468ACE0;
    m_lastdma = 32'h0;

    // Reset state
    step(); step();
    sys_rst = 1'b0;
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_csr_do", csr_do, 32'h0);
    chk("rst_dma_base", 32'(dma_base), 32'h0);
    wbm_adr_o = 32'hC0FFEE08; wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;

    // Configuration write and read-back
    csr_wr(15'h0001, 32'h12345678);
    chk("dma_base_out", 32'(dma_base), 32'h12345678 >> 3);
    csr_wr(15'h0002, 32'h00000045);
    chk("hmesh_out", 32'(hmesh_last), 32'h45);
    csr_rd(15'h0001, v); chk("dma_read", v, 32'h12345678);
    csr_rd(15'h0002, v); chk("hmesh_read", v, 32'h45);

    // Start while idle, three vertices, completion interrupt
    csr_wr(15'h0000, 32'h1);
    chk("start_pulse", 32'(start), 32'h1);
    busy = 1'b1;
    step();
    chk("start_one_cycle", 32'(start), 32'h0);
    for (int i = 0; i < 3; i++) begin
      vnext = 1'b1; step(); vnext = 1'b0; step();
    end
    busy = 1'b0;
    step(); chk("irq_after_1", 32'(irq), 32'h0);
    step(); chk("irq_after_2", 32'(irq), 32'h1);
    csr_rd(15'h0005, v); chk("vertex_count", v, DIAG ? 32'd3 : 32'd0);
    csr_rd(15'h000A, v); chk("isr_done", v, 32'h1);
    csr_wr(15'h000A, 32'h1);
    step(); chk("irq_w1c", 32'(irq), 32'h0);

    // Start while busy is rejected
    busy = 1'b1;
    step();
    csr_wr(15'h0000, 32'h1);
    chk("reject_no_start", 32'(start), 32'h0);
    step(); chk("reject_irq_masked", 32'(irq), 32'h0);
    csr_rd(15'h000A, v); chk("isr_rejected", v, 32'h2);
    csr_wr(15'h000B, 32'h3);
    step(); chk("irq_ier3", 32'(irq), 32'h1);
    busy = 1'b0;
    step();
    csr_wr(15'h000A, 32'h3);
    step(); step();

    // Counter saturation
    csr_wr(15'h0000, 32'h1);
    step();
    for (int i = 0; i < 20; i++) begin
      err_stray = 1'b1; step(); err_stray = 1'b0; step();
    end
    csr_rd(15'h0007, v); chk("stray_sat", v, DIAG ? 32'd15 : 32'd0);

    // Register file / program memory decode table
    for (int i = 0; i < 7; i++) begin
      csr_a = vecs[i].a; csr_we = vecs[i].we; csr_di = vecs[i].di;
      #1;
      chk("tbl_cr_w_en", 32'(cr_w_en), 32'(vecs[i].cr_w));
      chk("tbl_cp_w_en", 32'(cp_w_en), 32'(vecs[i].cp_w));
      chk("tbl_cr_addr", 32'(cr_addr), 32'(vecs[i].cr_a));
      chk("tbl_cp_offset", 32'(cp_offset), 32'(vecs[i].cp_off));
      chk("tbl_cr_do", cr_do, vecs[i].di);
      chk("tbl_cp_do", cp_do, vecs[i].di);
      step();
      csr_we = 1'b0; csr_a = IDLE_A;
    end
    cr_di = 32'hCAFEF00D;
    csr_rd(15'h0105, v); chk("regfile_read", v, 32'hCAFEF00D);
    cp_di = 32'h0BADC0DE;
    csr_rd(15'h0203, v); chk("progmem_read", v, 32'h0BADC0DE);
    step(); chk("unselected_zero", csr_do, 32'h0);

    // Reset in the middle of a run with a pending done interrupt
    busy = 1'b1; step();
    busy = 1'b0; step(); step();
    chk("pre_rst_irq", 32'(irq), 32'h1);
    busy = 1'b1; vnext = 1'b1; step(); step();
    vnext = 1'b0; sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    chk("midrun_rst_irq", 32'(irq), 32'h0);
    csr_rd(15'h000B, v); chk("midrun_rst_ier", v, 32'h1);
    csr_rd(15'h0005, v); chk("midrun_rst_vertex", v, 32'h0);
    csr_rd(15'h000A, v); chk("midrun_rst_isr", v, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3, 4, 5: csr_a = {5'h0, 2'b00, 4'($urandom), 4'($urandom)};
        6:                csr_a = {5'h0, 2'b01, 8'($urandom)};
        7:                csr_a = {5'h0, 1'b1, 9'($urandom)};
        default:          csr_a = {5'($urandom_range(1, 31)), 10'($urandom)};
      endcase
      csr_we        = ($urandom_range(0, 2) == 0);
      csr_di        = $urandom;
      if ($urandom_range(0, 7) == 0) busy = ~busy;
      vnext         = ($urandom_range(0, 2) == 0);
      err_collision = ($urandom_range(0, 3) == 0);
      err_stray     = ($urandom_range(0, 3) == 0);
      pc            = 11'($urandom);
      wbm_ack_i     = ($urandom_range(0, 3) == 0);
      wbm_adr_o     = $urandom;
      cr_di         = $urandom;
      cp_di         = $urandom;
      sys_rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    sys_rst = 1'b0; csr_we = 1'b0; csr_a = IDLE_A;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pfpu_ctlif2.md
# pfpu_ctlif2

Parametrised CSR control interface for the PFPU, the next generation of the existing controller. It sits between the CSR bus and the PFPU core. It owns the run configuration registers (DMA base, mesh size, program page) and muxes CSR access to the register file and program memory. It adds maskable sticky interrupts, busy-safe start, saturating diagnostic counters and a run-cycle counter.

## Interface
Parameters:
- csr_addr, 5'h0: CSR bank select, compared with csr_a[14:10].
- mesh_bits, 7: width of hmesh_last/vmesh_last.
- page_bits, 2: width of cp_page.
- cnt_bits, 14: width of vertex/collision/stray counters (≤32).

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- csr_a  in  15  CSR address
- csr_we  in  1  CSR write strobe
- csr_di  in  32  CSR write data
- csr_do  out  32  CSR read data
- irq  out  1  interrupt, level
- start  out  1  one-cycle run start pulse
- busy  in  1  core running
- dma_base  out  29  output buffer base, 8-byte units
- hmesh_last  out  mesh_bits  last horizontal mesh index
- vmesh_last  out  mesh_bits  last vertical mesh index
- cr_addr  out  7  register file address
- cr_di  in  32  register file read data
- cr_do  out  32  register file write data
- cr_w_en  out  1  register file write enable
- cp_page  out  page_bits  program memory page
- cp_offset  out  9  program memory offset
- cp_di  in  32  program memory read data
- cp_do  out  32  program memory write data
- cp_w_en  out  1  program memory write enable
- vnext  in  1  vertex completed
- err_collision  in  1  collision error event
- err_stray  in  1  stray error event
- pc  in  11  core program counter
- wbm_adr_o  in  32  DMA master address
- wbm_ack_i  in  1  DMA master acknowledge

## Operation
- sel = (csr_a[14:10]==csr_addr).
- Access decode:
  - csr_a[9]: program memory. cp_w_en = sel&a[9]&we.
  - csr_a[9:8]==01: register file. cr_w_en = sel&~a[9]&a[8]&we.
  - Otherwise: control registers, indexed by csr_a[3:0].
- Passthrough: cp_offset=a[8:0], cr_addr=a[6:0], cp_do=cr_do=csr_di.
- Control map (R/W unless noted):
  - 0 CTL: read {31'b0,busy}. Write bit0=1 requests start.
  - 1 DMA: {dma_base,3'b0}.
  - 2 HMESH. 3 VMESH. 4 PAGE.
  - 5 VERTEX, 6 COLL, 7 STRAY: RO, zero-extended.
  - 8 LASTDMA: RO, wbm_adr_o latched on wbm_ack_i.
  - 9 PC: RO.
  - A ISR: bit0 done, bit1 start_rejected. Write 1 to clear.
  - B IER: bits[1:0].
  - C RUNCYC: RO, 32-bit.
  - D–F: read 0, writes ignored.
- Start request handling:
  - busy=0: start pulses 1 cycle. Counters and RUNCYC clear; clear beats same-cycle increment.
  - busy=1: no pulse, no clear, ISR[1] set.
- Done detection: ISR[0] sets on the edge where old_busy=1 and busy=0.
- ISR set and W1C in the same cycle: set wins.
- irq register <= |(ISR & IER).
- Counters:
  - increment on their event; saturate at all-ones, no wrap.
  - RUNCYC increments each cycle busy=1; saturates at 32'hFFFFFFFF.

## Timing
- Reset values:
  - start=0, irq=0, dma_base=0, hmesh/vmesh_last=0, cp_page=0.
  - counters=0, ISR=0, IER=2'b01, csr_do=0.
  - last_dma is not reset.
- Read latency is 1 cycle for all sources. Select flags are registered; csr_do is the AND-OR of the registered control value, cp_di and cr_di. csr_do=0 one cycle after an unselected access.
- Write effect is visible on the following edge. start is high exactly one cycle after the write edge.
- irq is asserted 1 cycle after the ISR bit sets.
- Reset mid-run: all state returns to reset values on that edge; irq drops the next cycle.

## Configuration
- PFPU_CTLIF2_DIAG_EN defined: VERTEX, COLL, STRAY, LASTDMA, PC and RUNCYC are implemented.
- Not defined: their logic is omitted and these addresses read 0. The ISR/IER and start logic is unchanged.

## Test plan
- Write DMA=0x12345678, HMESH=0x45, then read both. Expect 0x12345678 and 0x45, each 1 cycle after the address.
- Start with busy=0 and 3 vnext pulses, then busy falls. Expect a 1-cycle start pulse, VERTEX=3, ISR=1, and irq asserted 2 cycles after busy falls. W1C of 1 deasserts irq.
- Start with busy=1. Expect no start, ISR[1]=1 and irq low (IER=01). Set IER=3: irq rises.
- With cnt_bits=4, apply 20 err_stray pulses. STRAY reads 15.
- Write regfile addr 0x105 = 0xDEADBEEF: cr_w_en=1, cr_addr=5. Write progmem addr 0x203: cp_w_en=1, cp_offset=0x003. Reads return cr_di/cp_di after 1 cycle.
- Pulse sys_rst during busy with ISR[0] set. Next cycle: irq=0, IER=1, counters 0.
